// File: rtl/psc_trigger_pkg.sv
// PSC trigger link: shared types, CRC constants and CRC-8 step function.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package psc_trigger_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // One byte through CRC-8 (poly 0x07), MSB first, no reflection, no final XOR.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/psc_trigger_uart_rx.sv
// Serial byte receiver: 2-FF synchronizer, start/data/stop bit FSM, bit timer.
// Latency: strobe is combinational in the stop-sample cycle (~2 sync clks + 9.5 bits after start edge).
// Backpressure: none; the line cannot be stalled, every accepted byte is strobed once.
module psc_trigger_uart_rx
  import psc_trigger_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       psc_input,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       rx_stop_err,
  output logic       rx_busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW   = $clog2(CLKS_PER_BIT + 1);

  logic            sync1;
  logic            sync2;
  logic            line_prev;
  rx_state_t       state;
  rx_state_t       state_nxt;
  logic [TW-1:0]   bit_timer;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            start_edge;
  logic            half_tick;
  logic            full_tick;

  assign start_edge = line_prev & ~sync2;
  assign half_tick  = (bit_timer == TW'(HALF));
  assign full_tick  = (bit_timer == TW'(CLKS_PER_BIT));
  assign rx_byte    = shift;

  // Synchronize the line and keep one delayed copy for falling-edge detect; idle level is 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync1     <= psc_input;
      sync2     <= sync1;
      line_prev <= sync2;
    end
  end

  // Bit FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Bit FSM next-state: half-bit start check, then full-bit sampling.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_edge) state_nxt = START;
      START:   if (half_tick)  state_nxt = sync2 ? IDLE : DATA;
      DATA:    if (full_tick && bit_cnt == 3'd7) state_nxt = STOP;
      STOP:    if (full_tick)  state_nxt = sync2 ? IDLE : BREAK;
      BREAK:   if (sync2)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timer, bit counter and LSB-first shift register; timer sits at 1 while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_timer <= TW'(1);
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
    end else begin
      case (state)
        START: begin
          if (half_tick) bit_timer <= TW'(1);
          else           bit_timer <= bit_timer + TW'(1);
        end
        DATA: begin
          if (full_tick) begin
            bit_timer <= TW'(1);
            bit_cnt   <= bit_cnt + 3'd1;
            shift     <= {sync2, shift[7:1]};
          end else begin
            bit_timer <= bit_timer + TW'(1);
          end
        end
        STOP: begin
          if (full_tick) bit_timer <= TW'(1);
          else           bit_timer <= bit_timer + TW'(1);
        end
        default: begin
          bit_timer <= TW'(1);
          bit_cnt   <= 3'd0;
        end
      endcase
    end
  end

  // Outputs: stop-sample verdict, and busy whenever a frame is in progress or starting now.
  always_comb begin
    rx_strobe   = (state == STOP) && full_tick && sync2;
    rx_stop_err = (state == STOP) && full_tick && !sync2;
    rx_busy     = (state != IDLE) || start_edge;
  end

endmodule

// File: rtl/psc_trigger_receiver.sv
// PSC trigger link receiver: packet assembly, CRC-8 check, inter-byte timeout, trigger decode.
// Latency: all strobes one clk after the stop-bit sample of the relevant byte.
// Backpressure: none; strobes are single-clk and must be consumed when asserted.
module psc_trigger_receiver
  import psc_trigger_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 5,
  parameter int         PKT_BYTES    = 2,
  parameter logic [7:0] TRIG_CODE    = 8'hA5,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       psc_input,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic [3:0] byte_index,
  output logic       packet_ok,
  output logic       crc_error,
  output logic       frame_error,
  output logic       trigger_out
);

  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  logic [7:0]      rx_byte;
  logic            rx_strobe;
  logic            rx_stop_err;
  logic            rx_busy;
  logic [3:0]      idx;
  logic [7:0]      crc;
  logic [7:0]      byte0;
  logic [TO_W-1:0] to_cnt;
  logic            to_run;
  logic            to_fire;

  psc_trigger_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .psc_input  (psc_input),
    .rx_byte    (rx_byte),
    .rx_strobe  (rx_strobe),
    .rx_stop_err(rx_stop_err),
    .rx_busy    (rx_busy)
  );

  // A start edge counts as busy, so it suppresses a timeout landing in the same clk.
  assign to_run  = !rx_busy && (idx != 4'd0);
  assign to_fire = to_run && (to_cnt == TO_W'(TO_LIMIT - 1));

  // Inter-byte idle timer: counts only while idle inside a packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (!to_run || to_fire) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Packet assembly: payload bytes, CRC compare, error discards; one strobe per event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out    <= 8'h00;
      data_valid  <= 1'b0;
      byte_index  <= 4'd0;
      packet_ok   <= 1'b0;
      crc_error   <= 1'b0;
      frame_error <= 1'b0;
      trigger_out <= 1'b0;
      idx         <= 4'd0;
      crc         <= CRC8_INIT;
      byte0       <= 8'h00;
    end else begin
      data_valid  <= 1'b0;
      packet_ok   <= 1'b0;
      crc_error   <= 1'b0;
      frame_error <= 1'b0;
      trigger_out <= 1'b0;
      if (rx_stop_err || to_fire) begin
        frame_error <= 1'b1;
        idx         <= 4'd0;
        crc         <= CRC8_INIT;
      end else if (rx_strobe) begin
        if (idx < 4'(PKT_BYTES)) begin
          data_out   <= rx_byte;
          byte_index <= idx;
          data_valid <= 1'b1;
          crc        <= crc8_byte(crc, rx_byte);
          if (idx == 4'd0) byte0 <= rx_byte;
          idx        <= idx + 4'd1;
        end else begin
          if (rx_byte == crc) begin
            packet_ok   <= 1'b1;
            trigger_out <= (byte0 == TRIG_CODE);
          end else begin
            crc_error   <= 1'b1;
          end
          idx <= 4'd0;
          crc <= CRC8_INIT;
        end
      end
    end
  end

endmodule

// File: tb/tb_psc_trigger_receiver.sv
// Directed bench for psc_trigger_receiver: drives serial frames, counts strobes, checks against hand values.
// Latency: n/a.
// Backpressure: n/a.
module tb_psc_trigger_receiver;

  localparam int CPB = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       psc_input;
  logic [7:0] data_out;
  logic       data_valid;
  logic [3:0] byte_index;
  logic       packet_ok;
  logic       crc_error;
  logic       frame_error;
  logic       trigger_out;

  psc_trigger_receiver #(
    .CLKS_PER_BIT(CPB),
    .PKT_BYTES   (2),
    .TRIG_CODE   (8'hA5),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .psc_input  (psc_input),
    .data_out   (data_out),
    .data_valid (data_valid),
    .byte_index (byte_index),
    .packet_ok  (packet_ok),
    .crc_error  (crc_error),
    .frame_error(frame_error),
    .trigger_out(trigger_out)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int dv_cnt, ok_cnt, crc_cnt, fe_cnt, trig_cnt, trig_alone;
  logic [11:0] dv_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_mon();
    dv_cnt = 0; ok_cnt = 0; crc_cnt = 0; fe_cnt = 0; trig_cnt = 0; trig_alone = 0;
    dv_q.delete();
  endtask

  // Strobe monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt++;
      dv_q.push_back({data_out, byte_index});
    end
    if (packet_ok)   ok_cnt++;
    if (crc_error)   crc_cnt++;
    if (frame_error) fe_cnt++;
    if (trigger_out) trig_cnt++;
    if (trigger_out && !packet_ok) trig_alone++;
  end

  task automatic idle_bits(input int n);
    psc_input = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      psc_input = frame[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    idle_bits(4);
  endtask

  task automatic check_good_trigger(input string tag);
    check({tag, ".dv_cnt"}, dv_cnt, 2);
    check({tag, ".ok"}, ok_cnt, 1);
    check({tag, ".trig"}, trig_cnt, 1);
    check({tag, ".trig_alone"}, trig_alone, 0);
    check({tag, ".fe"}, fe_cnt, 0);
  endtask

  initial begin
    reset = 1'b1;
    psc_input = 1'b1;
    clear_mon();
    repeat (3) @(negedge clk);
    check("rst.data_out", data_out, 8'h00);
    check("rst.data_valid", data_valid, 0);
    check("rst.byte_index", byte_index, 0);
    check("rst.packet_ok", packet_ok, 0);
    check("rst.crc_error", crc_error, 0);
    check("rst.frame_error", frame_error, 0);
    check("rst.trigger_out", trigger_out, 0);
    reset = 1'b0;
    idle_bits(2);

    // 1: trigger packet, back-to-back bytes
    clear_mon();
    send_pkt(8'hA5, 8'h00, 8'h59);
    check_good_trigger("t1");
    check("t1.byte0", (dv_q.size() > 0) ? dv_q[0] : 12'hfff, {8'hA5, 4'd0});
    check("t1.byte1", (dv_q.size() > 1) ? dv_q[1] : 12'hfff, {8'h00, 4'd1});
    check("t1.crc_err", crc_cnt, 0);
    check("t1.data_out_hold", data_out, 8'h00);

    // 2: good packet, non-trigger code (CRC of 3C,00 = 05)
    clear_mon();
    send_pkt(8'h3C, 8'h00, 8'h05);
    check("t2.ok", ok_cnt, 1);
    check("t2.trig", trig_cnt, 0);
    check("t2.byte0", (dv_q.size() > 0) ? dv_q[0] : 12'hfff, {8'h3C, 4'd0});

    // 3: bad CRC, then a good trigger packet
    clear_mon();
    send_pkt(8'hA5, 8'h00, 8'h58);
    check("t3.crc_err", crc_cnt, 1);
    check("t3.ok", ok_cnt, 0);
    check("t3.trig", trig_cnt, 0);
    clear_mon();
    send_pkt(8'hA5, 8'h00, 8'h59);
    check_good_trigger("t3b");

    // 4: stop bit forced 0, line held low, then recovery
    clear_mon();
    send_byte(8'hA5, 1'b0);
    psc_input = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    idle_bits(3);
    check("t4.fe", fe_cnt, 1);
    check("t4.dv", dv_cnt, 0);
    clear_mon();
    send_pkt(8'hA5, 8'h00, 8'h59);
    check_good_trigger("t4b");

    // 5: short glitch, then inter-byte timeout, then recovery
    clear_mon();
    psc_input = 1'b0;
    repeat (2) @(negedge clk);
    idle_bits(3);
    check("t5.glitch_strobes", dv_cnt + ok_cnt + crc_cnt + fe_cnt + trig_cnt, 0);
    send_byte(8'hA5, 1'b1);
    idle_bits(25);
    check("t5.timeout_fe", fe_cnt, 1);
    check("t5.timeout_dv", dv_cnt, 1);
    check("t5.timeout_ok", ok_cnt, 0);
    clear_mon();
    send_pkt(8'hA5, 8'h00, 8'h59);
    check_good_trigger("t5b");

    // 6: reset during the data bits of byte 1
    send_byte(8'hA5, 1'b1);
    fork
      send_byte(8'h00, 1'b1);
      begin
        repeat (3 * CPB) @(negedge clk);
        clear_mon();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("t6.rst_data_out", data_out, 8'h00);
        check("t6.rst_byte_index", byte_index, 0);
      end
    join
    repeat (5) @(negedge clk);
    reset = 1'b0;
    idle_bits(25);
    check("t6.no_strobes", dv_cnt + ok_cnt + crc_cnt + fe_cnt + trig_cnt, 0);
    clear_mon();
    send_pkt(8'hA5, 8'h00, 8'h59);
    check_good_trigger("t6b");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
